// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Decoupling FIFO between the PC/fetch stage and decode. Each accepted
//   {pc, pc_plus4, instr} triple is stored in a DEPTH-entry circular buffer.
//   The oldest entry is presented to decode through a valid/ready handshake.
//   A flush on a control-flow redirect discards every buffered entry.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid        : fetch presents an entry
//   in_ready        : queue can accept (== !full, from registered count only)
//   in_pc           : fetched instruction address
//   in_pc_plus4     : return address (in_pc + 4)
//   in_instr        : fetched instruction word
//   flush           : redirect, discard all entries (push/pop that cycle dropped)
//   out_valid       : head entry valid (== !empty, from registered count only)
//   out_ready       : decode consumes head this cycle
//   out_pc          : head pc, 0 when empty
//   out_pc_plus4    : head pc_plus4, 0 when empty
//   out_instr       : head instruction, NOP_INSTR when empty
//   count           : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [WIDTH-1:0]           in_pc_plus4,
  input  logic [31:0]                in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_pc,
  output logic [WIDTH-1:0]           out_pc_plus4,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage: contents are don't-care after reset/flush because count gates
  // every read, so the array carries no reset.
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] pc4_mem_q   [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic full_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Handshake qualifiers. full/empty come from the registered count only, so
  // a pop on a full queue does not open in_ready until the following cycle.
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    push_s  = in_valid & ~full_s;
    pop_s   = ~empty_s & out_ready;
  end

  // Next-state for pointers and occupancy; flush overrides any push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so the
      // increment wraps DEPTH-1 -> 0 naturally.
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push_s && !flush && !rst) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      pc4_mem_q[wr_ptr_q]   <= in_pc_plus4;
      instr_mem_q[wr_ptr_q] <= in_instr;
    end
  end

  // Output drive: head entry when occupied, benign NOP bubble when empty.
  // No bypass from in_* so a push is visible only after its clock edge.
  always_comb begin
    if (!empty_s) begin
      out_pc       = pc_mem_q[rd_ptr_q];
      out_pc_plus4 = pc4_mem_q[rd_ptr_q];
      out_instr    = instr_mem_q[rd_ptr_q];
    end else begin
      out_pc       = {WIDTH{1'b0}};
      out_pc_plus4 = {WIDTH{1'b0}};
      out_instr    = NOP_INSTR;
    end
  end

  assign in_ready  = ~full_s;
  assign out_valid = ~empty_s;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed self-checking bench for fetch_queue (WIDTH=32, DEPTH=4).
//   Inputs change #1 after the rising edge; outputs are compared at that
//   same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int check_cnt;
  int err_cnt;

  fetch_queue #(
    .WIDTH     (32),
    .DEPTH     (4),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_pc_plus4  (in_pc_plus4),
    .in_instr     (in_instr),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .out_instr    (out_instr),
    .count        (count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct instruction word per pc so ordering errors are visible.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hABC0_0093 ^ pc;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc);
    in_valid    = v;
    in_pc       = pc;
    in_pc_plus4 = pc + 32'd4;
    in_instr    = instr_of(pc);
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_count"},  64'(count), 64'd0);
    check_eq({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_iready"}, 64'(in_ready), 64'd1);
    check_eq({tag, "_opc"},    64'(out_pc), 64'd0);
    check_eq({tag, "_opc4"},   64'(out_pc_plus4), 64'd0);
    check_eq({tag, "_oinstr"}, 64'(out_instr), 64'(NOP));
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_ovalid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_opc"},    64'(out_pc), 64'(pc));
    check_eq({tag, "_opc4"},   64'(out_pc_plus4), 64'(pc + 32'd4));
    check_eq({tag, "_oinstr"}, 64'(out_instr), 64'(instr_of(pc)));
  endtask

  initial begin
    check_cnt   = 0;
    err_cnt     = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    out_ready   = 1'b0;
    set_in(1'b0, 32'h0);

    // 1. reset then idle
    step();
    step();
    rst = 1'b0;
    check_empty("reset");
    step();
    check_empty("idle");

    // 2. single push, held stable while out_ready=0
    in_valid    = 1'b1;
    in_pc       = 32'h0;
    in_pc_plus4 = 32'h4;
    in_instr    = 32'h0050_0093;
    step();
    set_in(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_eq("single_opc",    64'(out_pc), 64'h0);
      check_eq("single_oinstr", 64'(out_instr), 64'h0050_0093);
      check_eq("single_opc4",   64'(out_pc_plus4), 64'h4);
      check_eq("single_count",  64'(count), 64'd1);
      check_eq("single_ovalid", 64'(out_valid), 64'd1);
      step();
    end

    // 3. fill (pc 0x0 already in), back-pressure, one pop, refill
    for (int i = 1; i < 4; i++) begin
      set_in(1'b1, 32'(i * 4));
      step();
    end
    check_eq("full_count",  64'(count), 64'd4);
    check_eq("full_iready", 64'(in_ready), 64'd0);
    set_in(1'b1, 32'h10);
    step();
    check_eq("bp_count", 64'(count), 64'd4);
    check_eq("bp_opc",   64'(out_pc), 64'h0);
    out_ready = 1'b1;   // pop while full: 0x10 must not slip in this cycle
    step();
    out_ready = 1'b0;
    check_eq("pop_count",  64'(count), 64'd3);
    check_eq("pop_iready", 64'(in_ready), 64'd1);
    check_eq("pop_opc",    64'(out_pc), 64'h4);
    step();             // 0x10 accepted now
    set_in(1'b0, 32'h0);
    check_eq("refill_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check_head("drain", 32'(i * 4));
      step();
    end
    out_ready = 1'b0;
    check_empty("drained");

    // empty queue ignores out_ready
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_empty("underflow");

    // 4. steady push/pop at count=2 with pointer wrap
    set_in(1'b1, 32'h0);
    step();
    set_in(1'b1, 32'h4);
    step();
    check_eq("ss_prime_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'(8 + i * 4));
      check_head("ss", 32'(i * 4));
      step();
      check_eq("ss_count", 64'(count), 64'd2);
    end
    set_in(1'b0, 32'h0);
    out_ready = 1'b0;
    check_head("ss_after", 32'h28);

    // 5. flush mid-stream
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_empty("preflush");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(32'h20 + i * 4));
      step();
    end
    check_eq("fl_count", 64'(count), 64'd3);
    check_head("fl_head", 32'h20);
    set_in(1'b1, 32'h2C);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    out_ready = 1'b0;
    set_in(1'b0, 32'h0);
    check_empty("flush");
    step();
    check_empty("flush_noenq");
    set_in(1'b1, 32'h100);
    step();
    set_in(1'b0, 32'h0);
    check_head("postflush", 32'h100);
    check_eq("postflush_count", 64'(count), 64'd1);

    // 6. reset mid-operation with in_valid high
    for (int i = 1; i < 4; i++) begin
      set_in(1'b1, 32'(32'h100 + i * 4));
      step();
    end
    check_eq("prerst_count", 64'(count), 64'd4);
    set_in(1'b1, 32'h200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_in(1'b0, 32'h0);
    check_empty("midrst");
    step();
    check_empty("midrst_nostale");
    set_in(1'b1, 32'h300);
    step();
    set_in(1'b0, 32'h0);
    check_head("postrst", 32'h300);
    check_eq("postrst_count", 64'(count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end

endmodule
